// File: rtl/ghost_pkg.sv
// ghost_pkg: direction/mode encodings and direction helpers shared by the ghost controller
package ghost_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_UP    = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'b00,
    MODE_CHASE   = 2'b01,
    MODE_FRIGHT  = 2'b10
  } mode_t;

  // Opposite direction is always the code with bit 1 flipped
  function automatic dir_t reverseDir(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/ghost_lfsr.sv
// ghost_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that advances only on enabled ticks
module ghost_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       move_clk,
  input  logic       reset,
  input  logic       enable,
  output logic [1:0] pick
);

  logic [7:0] state;

  always_ff @(posedge move_clk or posedge reset)
    if (reset) state <= SEED;
    else if (enable) state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};

  assign pick = state[1:0];

endmodule

// File: rtl/ghost_dir_ctrl.sv
// ghost_dir_ctrl: per-ghost SCATTER/CHASE/FRIGHT mode FSM with periodic target-seeking direction choice
module ghost_dir_ctrl
  import ghost_pkg::*;
#(
  parameter logic [10:0] SCATTER_TICKS = 11'd420,
  parameter logic [10:0] CHASE_TICKS   = 11'd1200,
  parameter logic [10:0] FRIGHT_TICKS  = 11'd360,
  parameter logic [3:0]  DECIDE_PERIOD = 4'd8,
  parameter logic [4:0]  SPEED_NORMAL  = 5'd2,
  parameter logic [4:0]  SPEED_FRIGHT  = 5'd1,
  parameter logic [9:0]  CORNER_X      = 10'd0,
  parameter logic [9:0]  CORNER_Y      = 10'd0,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       move_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       powerPellet,
  input  logic       ghostEaten,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  output logic [1:0] direction,
  output logic [4:0] speed,
  output logic [1:0] mode,
  output logic       frightened
);

  mode_t       modeQ, modeD, savedQ, savedD;
  dir_t        dirQ, dirD, primDir, secDir, trackDir, frightDir, cand;
  logic [10:0] timerQ, timerD, dx, dy, adx, ady;
  logic [9:0]  tx, ty;
  logic [3:0]  cntQ, cntD;
  logic [4:0]  speedQ;
  logic [1:0]  pick;
  logic        frightQ, modeChange, decide, horiz;

  ghost_lfsr #(.SEED(LFSR_SEED)) uLfsr (
    .move_clk(move_clk),
    .reset   (reset),
    .enable  (enable),
    .pick    (pick)
  );

  // Target selection and the two candidate decisions (tracking and frightened)
  always_comb begin
    tx        = modeQ == MODE_SCATTER ? CORNER_X : pacX;
    ty        = modeQ == MODE_SCATTER ? CORNER_Y : pacY;
    dx        = {1'b0, tx} - {1'b0, ghostX};
    dy        = {1'b0, ty} - {1'b0, ghostY};
    adx       = dx[10] ? -dx : dx;
    ady       = dy[10] ? -dy : dy;
    horiz     = adx >= ady;
    primDir   = horiz ? (dx[10] ? DIR_LEFT : DIR_RIGHT) : (dy[10] ? DIR_UP : DIR_DOWN);
    secDir    = horiz ? (dy[10] ? DIR_UP : DIR_DOWN) : (dx[10] ? DIR_LEFT : DIR_RIGHT);
    trackDir  = (~|dx && ~|dy) ? dirQ : primDir == reverseDir(dirQ) ? secDir : primDir;
    cand      = dir_t'(pick);
    frightDir = cand == reverseDir(dirQ) ? dir_t'(cand ^ 2'b01) : cand;
  end

  always_comb begin
    modeD      = modeQ;
    savedD     = savedQ;
    timerD     = timerQ - 11'd1;
    modeChange = 1'b1;
    if (powerPellet) begin
      modeD  = MODE_FRIGHT;
      timerD = FRIGHT_TICKS;
      savedD = modeQ == MODE_FRIGHT ? savedQ : modeQ;
    end else if (ghostEaten && modeQ == MODE_FRIGHT) begin
      modeD  = MODE_CHASE;
      timerD = CHASE_TICKS;
    end else if (timerQ == 11'd0) begin
      modeD  = modeQ == MODE_SCATTER ? MODE_CHASE : modeQ == MODE_CHASE ? MODE_SCATTER : savedQ;
      timerD = modeD == MODE_SCATTER ? SCATTER_TICKS : CHASE_TICKS;
    end else begin
      modeChange = 1'b0;
    end
    decide = !modeChange && cntQ == 4'd0;
    cntD   = (modeChange || decide) ? DECIDE_PERIOD - 4'd1 : cntQ - 4'd1;
    dirD   = modeChange ? reverseDir(dirQ) : !decide ? dirQ : modeQ == MODE_FRIGHT ? frightDir : trackDir;
  end

  always_ff @(posedge move_clk or posedge reset)
    if (reset) begin
      modeQ   <= MODE_SCATTER;
      savedQ  <= MODE_SCATTER;
      timerQ  <= SCATTER_TICKS;
      dirQ    <= DIR_LEFT;
      cntQ    <= DECIDE_PERIOD - 4'd1;
      speedQ  <= SPEED_NORMAL;
      frightQ <= 1'b0;
    end else if (enable) begin
      modeQ   <= modeD;
      savedQ  <= savedD;
      timerQ  <= timerD;
      dirQ    <= dirD;
      cntQ    <= cntD;
      speedQ  <= modeD == MODE_FRIGHT ? SPEED_FRIGHT : SPEED_NORMAL;
      frightQ <= modeD == MODE_FRIGHT;
    end

  assign direction  = dirQ;
  assign speed      = enable ? speedQ : 5'd0;
  assign mode       = modeQ;
  assign frightened = frightQ;

endmodule

// File: tb/tb_ghost_dir_ctrl.sv
// tb_ghost_dir_ctrl: scoreboard bench checking ghost_dir_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_ghost_dir_ctrl;

  logic       move_clk = 1'b0, reset = 1'b1, enable = 1'b1, powerPellet = 1'b0, ghostEaten = 1'b0;
  logic [9:0] pacX, pacY, ghostX, ghostY;
  logic [1:0] direction, mode;
  logic [4:0] speed;
  logic       frightened;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] dir;
    logic [4:0] speed;
    logic       fr;
    logic [7:0] lfsr;
    logic       frDec;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0, fails = 0, frDecCount = 0;
  int         mMode, mTimer, mSaved, mDir, mCnt;
  logic [7:0] mLfsr;
  bit         frDec;

  ghost_dir_ctrl dut (
    .move_clk   (move_clk),
    .reset      (reset),
    .enable     (enable),
    .powerPellet(powerPellet),
    .ghostEaten (ghostEaten),
    .pacX       (pacX),
    .pacY       (pacY),
    .ghostX     (ghostX),
    .ghostY     (ghostY),
    .direction  (direction),
    .speed      (speed),
    .mode       (mode),
    .frightened (frightened)
  );

  always #5 move_clk = ~move_clk;

  task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mMode = 0; mTimer = 420; mSaved = 0; mDir = 0; mCnt = 7; mLfsr = 8'hA5;
  endtask

  task automatic modelStep();
    int  nMode, nTimer, tx, ty, dx, dy, p, s;
    bit  chg;
    frDec = 0;
    if (!enable) return;
    nMode  = mMode;
    nTimer = mTimer - 1;
    chg    = 1;
    if (powerPellet) begin
      nMode = 2; nTimer = 360;
      if (mMode != 2) mSaved = mMode;
    end else if (ghostEaten && mMode == 2) begin
      nMode = 1; nTimer = 1200;
    end else if (mTimer == 0) begin
      nMode  = (mMode == 0) ? 1 : (mMode == 1) ? 0 : mSaved;
      nTimer = (nMode == 0) ? 420 : 1200;
    end else chg = 0;
    if (chg) begin
      mDir = mDir ^ 2; mCnt = 7;
    end else if (mCnt > 0) mCnt--;
    else begin
      mCnt = 7;
      if (mMode == 2) begin
        p = mLfsr[1:0];
        mDir = (p == (mDir ^ 2)) ? (p ^ 1) : p;
        frDec = 1;
      end else begin
        tx = (mMode == 0) ? 0 : pacX;
        ty = (mMode == 0) ? 0 : pacY;
        dx = tx - ghostX;
        dy = ty - ghostY;
        if (dx != 0 || dy != 0) begin
          if ((dx < 0 ? -dx : dx) >= (dy < 0 ? -dy : dy)) begin
            p = dx < 0 ? 0 : 2; s = dy < 0 ? 1 : 3;
          end else begin
            p = dy < 0 ? 1 : 3; s = dx < 0 ? 0 : 2;
          end
          mDir = (p == (mDir ^ 2)) ? s : p;
        end
      end
    end
    mMode  = nMode;
    mTimer = nTimer;
    mLfsr  = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
  endtask

  task automatic cyc();
    exp_t       e;
    logic [1:0] prev;
    prev = direction;
    modelStep();
    e.mode  = 2'(mMode);
    e.dir   = 2'(mDir);
    e.speed = enable ? ((mMode == 2) ? 5'd1 : 5'd2) : 5'd0;
    e.fr    = (mMode == 2);
    e.lfsr  = mLfsr;
    e.frDec = frDec;
    sb.push_back(e);
    @(posedge move_clk);
    #1;
    e = sb.pop_front();
    expectEq("mode", mode, e.mode);
    expectEq("dir", direction, e.dir);
    expectEq("speed", speed, e.speed);
    expectEq("fright", frightened, e.fr);
    expectEq("lfsr", dut.uLfsr.state, e.lfsr);
    if (e.frDec) begin
      frDecCount++;
      expectEq("frNoReverse", direction == (prev ^ 2'b10), 0);
    end
  endtask

  task automatic checkResetState(input string tag);
    expectEq({tag, "Mode"}, mode, 0);
    expectEq({tag, "Dir"}, direction, 0);
    expectEq({tag, "Speed"}, speed, 2);
    expectEq({tag, "Fright"}, frightened, 0);
    expectEq({tag, "Lfsr"}, dut.uLfsr.state, 8'hA5);
  endtask

  initial begin
    pacX = 10'd100; pacY = 10'd0; ghostX = 10'd100; ghostY = 10'd100;
    modelReset();
    #12;
    checkResetState("rst");
    @(negedge move_clk) reset = 1'b0;
    // SCATTER runs 420 decrements plus the expiry edge
    repeat (420) cyc();
    expectEq("scatterHold", mode, 0);
    cyc();
    expectEq("toChaseMode", mode, 1);
    expectEq("toChaseDir", direction, 2);
    repeat (8) cyc();
    expectEq("chaseUp", direction, 1);
    pacX = 10'd200; pacY = 10'd150;
    repeat (8) cyc();
    expectEq("chaseRight", direction, 2);
    ghostX = 10'd200; pacX = 10'd50; pacY = 10'd120;
    repeat (8) cyc();
    expectEq("chaseSecondary", direction, 3);
    powerPellet = 1'b1; cyc(); powerPellet = 1'b0;
    expectEq("pelletMode", mode, 2);
    expectEq("pelletFright", frightened, 1);
    expectEq("pelletSpeed", speed, 1);
    expectEq("pelletRev", direction, 1);
    repeat (360) cyc();
    expectEq("frightHold", mode, 2);
    cyc();
    expectEq("frightExit", mode, 1);
    expectEq("frightExitSpeed", speed, 2);
    for (int k = 0; k < 20 && frDecCount < 64; k++) begin
      powerPellet = 1'b1; cyc(); powerPellet = 1'b0;
      repeat (300) cyc();
    end
    expectEq("frDecisions", frDecCount >= 64, 1);
    powerPellet = 1'b1; ghostEaten = 1'b1; cyc(); powerPellet = 1'b0; ghostEaten = 1'b0;
    expectEq("ppGeMode", mode, 2);
    repeat (360) cyc();
    expectEq("reloadHold", mode, 2);
    cyc();
    expectEq("reloadExit", mode, 1);
    powerPellet = 1'b1; cyc(); powerPellet = 1'b0;
    repeat (5) cyc();
    ghostEaten = 1'b1; cyc(); ghostEaten = 1'b0;
    expectEq("eatenMode", mode, 1);
    expectEq("eatenSpeed", speed, 2);
    repeat (1200) cyc();
    expectEq("eatenHold", mode, 1);
    cyc();
    expectEq("eatenExit", mode, 0);
    ghostEaten = 1'b1; cyc(); ghostEaten = 1'b0;
    expectEq("eatenScatter", mode, 0);
    repeat (10) cyc();
    enable = 1'b0;
    #1;
    expectEq("disSpeed", speed, 0);
    repeat (100) cyc();
    enable = 1'b1;
    repeat (20) cyc();
    powerPellet = 1'b1; cyc(); powerPellet = 1'b0;
    repeat (3) cyc();
    expectEq("preRstFright", frightened, 1);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkResetState("midRst");
    @(negedge move_clk) reset = 1'b0;
    repeat (30) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
